wb_slave_router: RTL and testbench
==================================

// Module: wb_slave_router
// PURPOSE
//  Parametrised Wishbone address decoder and response mux between the Caravel user-project
//  Wishbone slave port and NUM_SLV user slaves (exmem, fir, matmul, qsort, ...).
//  The base/mask address map is set by parameters, and the slave index is registered per transaction.
//  Adds per-transaction timeout, error response for unmapped or timed-out accesses, and fault capture with a sticky IRQ.
// PARAMETERS
//  NUM_SLV   4                         number of downstream slaves (1..8)
//  BASE      {32'h3800_0000,32'h3000_0200,32'h3000_0100,32'h3000_0000}  packed base per slave, slave 0 in LSBs
//  MASK      {32'hFF00_0000,32'hFF00_0F00,32'hFF00_0F00,32'hFF00_0F00}  packed compare mask per slave
//  TIMEOUT   255                       cycles in WAIT without ack before an error response (>=1)
//  ERR_DATA  32'hDEAD_BEEF             read data returned on an error response
// PORTS
//  wb_clk_i      in   1             clock
//  wb_rst_i      in   1             synchronous active-high reset
//  wbs_cyc_i     in   1             master cycle
//  wbs_stb_i     in   1             master strobe
//  wbs_we_i      in   1             master write enable
//  wbs_sel_i     in   4             master byte select
//  wbs_adr_i     in   32            master address
//  wbs_dat_i     in   32            master write data
//  wbs_ack_o     out  1             ack to master
//  wbs_dat_o     out  32            read data to master
//  s_valid_o     out  NUM_SLV       one-hot slave request (the wb_valid of each slave)
//  s_we_o/s_sel_o/s_adr_o/s_dat_o  out 1/4/32/32   broadcast copies of the master signals
//  s_ack_i       in   NUM_SLV       per-slave ack
//  s_dat_i       in   32*NUM_SLV    per-slave read data, slave k at [32k+31:32k]
//  fault_adr_o   out  32            address of the most recent faulted access
//  fault_cnt_o   out  8             saturating fault counter
//  err_irq_o     out  1             sticky fault flag
//  irq_clr_i     in   1             clears err_irq_o and fault_cnt_o
// BEHAVIOUR
//  - Hit k: (wbs_adr_i & MASK[k]) == (BASE[k] & MASK[k]). On overlapping hits, the lowest k wins.
//  - Reset: FSM=IDLE. wbs_ack_o=0, wbs_dat_o=0, s_valid_o=0, fault_adr_o=0, fault_cnt_o=0, err_irq_o=0, timeout counter=0.
//  - FSM states: IDLE, WAIT, ERR.
//    IDLE: when cyc&stb, register the hit index.
//      Any hit -> WAIT with the counter cleared.
//      No hit -> ERR and capture fault_adr_o.
//    WAIT: s_valid_o[idx]=cyc&stb.
//      wbs_ack_o=s_ack_i[idx] and wbs_dat_o=s_dat_i[idx] combinationally; the same cycle -> IDLE.
//      Acks from non-selected slaves are ignored.
//      The counter increments each cycle without ack. Counter==TIMEOUT-1 with no ack -> ERR: s_valid_o drops and fault_adr_o is captured.
//      cyc or stb low (master abort) -> IDLE; no ack, no fault.
//    ERR: wbs_ack_o=1 for exactly one cycle with wbs_dat_o=ERR_DATA; writes are discarded -> IDLE.
//  - Outside the WAIT-ack and ERR cycles, wbs_ack_o=0 and wbs_dat_o=0.
//  - Latency: one decode cycle, then the slave latency (min 2 cycles stb->ack). Unmapped access: ack on cycle 2. Timeout: ack at TIMEOUT+2.
//  - Faults: fault_cnt_o increments on entry to ERR and saturates at 8'hFF. err_irq_o is set on entry to ERR.
//  - Fault vs clear: irq_clr_i clears err_irq_o and fault_cnt_o, and wins over a simultaneous fault entry. fault_adr_o still updates.
//  - The master drops stb the cycle after ack. IDLE therefore never re-decodes the completed access; back-to-back accesses are legal.
//  - Reset mid-transaction: everything returns to reset values on the next edge, and a pending slave ack is ignored.
// TESTING
//  1 Read 0x3000_0104, slave 1 acks 2 cycles after s_valid_o[1] with 0x1234_5678 -> s_valid_o=4'b0010; wbs_dat_o=0x1234_5678 in the ack cycle.
//  2 Write 0x3000_0F00 (unmapped) -> ack on cycle 2 with dat=0xDEAD_BEEF; s_valid_o stays 0; fault_adr_o=0x3000_0F00; fault_cnt_o=1; err_irq_o=1.
//  3 TIMEOUT=8, access 0x3800_0000 with slave 3 never acking -> s_valid_o[3] high for 8 cycles, then ERR ack; fault_cnt_o increments.
//  4 Slave 2 acks while slave 0 is selected -> wbs_ack_o stays 0 until s_ack_i[0]; a stray irq_clr_i pulse during ERR leaves err_irq_o=0 and fault_cnt_o=0.
//  5 Master drops cyc in WAIT; wb_rst_i pulsed mid-WAIT -> FSM=IDLE, no ack; a later slave ack is ignored; all outputs at reset values.
//  6 256 unmapped accesses, then one more -> fault_cnt_o holds 8'hFF; back-to-back reads of slaves 0,3,0 each return the correct data.

Source files
------------

// File: rtl/wb_slave_router.sv
// Wishbone address decoder and response mux from the Caravel user slave port to NUM_SLV slaves.
// Adds a per-access timeout, error responses for unmapped/timed-out accesses and sticky fault capture.
module wb_slave_router #(
    parameter int                    NUM_SLV  = 4,
    parameter logic [32*NUM_SLV-1:0] BASE     = {32'h3800_0000, 32'h3000_0200, 32'h3000_0100, 32'h3000_0000},
    parameter logic [32*NUM_SLV-1:0] MASK     = {32'hFF00_0000, 32'hFF00_0F00, 32'hFF00_0F00, 32'hFF00_0F00},
    parameter int                    TIMEOUT  = 255,
    parameter logic [31:0]           ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic [NUM_SLV-1:0]      s_valid_o,
    output logic                    s_we_o,
    output logic [3:0]              s_sel_o,
    output logic [31:0]             s_adr_o,
    output logic [31:0]             s_dat_o,
    input  logic [NUM_SLV-1:0]      s_ack_i,
    input  logic [32*NUM_SLV-1:0]   s_dat_i,
    output logic [31:0]             fault_adr_o,
    output logic [7:0]              fault_cnt_o,
    output logic                    err_irq_o,
    input  logic                    irq_clr_i
);

    localparam int IW = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ERR} state_t;

    state_t        state;
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;

    logic          req;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic          sel_ack;
    logic          enter_err;
    logic [31:0]   s_dat_arr [NUM_SLV];

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign s_we_o  = wbs_we_i;
    assign s_sel_o = wbs_sel_i;
    assign s_adr_o = wbs_adr_i;
    assign s_dat_o = wbs_dat_i;

    // Descending scan so the lowest matching slave index overrides higher ones.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = NUM_SLV - 1; k >= 0; k--) begin
            if ((wbs_adr_i & MASK[32*k +: 32]) == (BASE[32*k +: 32] & MASK[32*k +: 32])) begin
                hit     = 1'b1;
                hit_idx = IW'(k);
            end
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_SLV; k++) begin
            s_dat_arr[k] = s_dat_i[32*k +: 32];
        end
    end

    // An abort (cyc/stb low) masks the selected slave's ack so it never reaches the master.
    assign sel_ack   = (state == WAIT) && req && s_ack_i[idx];
    assign enter_err = ((state == IDLE) && req && !hit) ||
                       ((state == WAIT) && req && !s_ack_i[idx] && (cnt == CNT_LAST));

    // Ack and read data pass straight through from the slave so its latency is not extended.
    always_comb begin
        s_valid_o = '0;
        wbs_ack_o = 1'b0;
        wbs_dat_o = '0;
        if ((state == WAIT) && req) begin
            s_valid_o[idx] = 1'b1;
        end
        if (state == ERR) begin
            wbs_ack_o = 1'b1;
            wbs_dat_o = ERR_DATA;
        end else if (sel_ack) begin
            wbs_ack_o = 1'b1;
            wbs_dat_o = s_dat_arr[idx];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= IDLE;
            idx         <= '0;
            cnt         <= '0;
            fault_adr_o <= '0;
            fault_cnt_o <= '0;
            err_irq_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        idx <= hit_idx;
                        cnt <= '0;
                        state <= hit ? WAIT : ERR;
                    end
                end
                WAIT: begin
                    if (!req || s_ack_i[idx]) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state <= ERR;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                ERR: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (enter_err) begin
                fault_adr_o <= wbs_adr_i;
            end

            // A clear in the same cycle as a new fault leaves both flag and counter cleared.
            if (irq_clr_i) begin
                err_irq_o   <= 1'b0;
                fault_cnt_o <= '0;
            end else if (enter_err) begin
                err_irq_o <= 1'b1;
                if (fault_cnt_o != 8'hFF) begin
                    fault_cnt_o <= fault_cnt_o + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_wb_slave_router.sv
// Self-checking bench for wb_slave_router: scoreboard of expected ack data plus
// latency, fault-capture and reset checks.
module tb_wb_slave_router;

    localparam int          NUM_SLV  = 4;
    localparam int          TIMEOUT  = 8;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    logic                  wb_clk_i;
    logic                  wb_rst_i;
    logic                  wbs_cyc_i;
    logic                  wbs_stb_i;
    logic                  wbs_we_i;
    logic [3:0]            wbs_sel_i;
    logic [31:0]           wbs_adr_i;
    logic [31:0]           wbs_dat_i;
    logic                  wbs_ack_o;
    logic [31:0]           wbs_dat_o;
    logic [NUM_SLV-1:0]    s_valid_o;
    logic                  s_we_o;
    logic [3:0]            s_sel_o;
    logic [31:0]           s_adr_o;
    logic [31:0]           s_dat_o;
    logic [NUM_SLV-1:0]    s_ack_i;
    logic [32*NUM_SLV-1:0] s_dat_i;
    logic [31:0]           fault_adr_o;
    logic [7:0]            fault_cnt_o;
    logic                  err_irq_o;
    logic                  irq_clr_i;

    wb_slave_router #(
        .NUM_SLV (NUM_SLV),
        .TIMEOUT (TIMEOUT),
        .ERR_DATA(ERR_DATA)
    ) dut (
        .wb_clk_i   (wb_clk_i),
        .wb_rst_i   (wb_rst_i),
        .wbs_cyc_i  (wbs_cyc_i),
        .wbs_stb_i  (wbs_stb_i),
        .wbs_we_i   (wbs_we_i),
        .wbs_sel_i  (wbs_sel_i),
        .wbs_adr_i  (wbs_adr_i),
        .wbs_dat_i  (wbs_dat_i),
        .wbs_ack_o  (wbs_ack_o),
        .wbs_dat_o  (wbs_dat_o),
        .s_valid_o  (s_valid_o),
        .s_we_o     (s_we_o),
        .s_sel_o    (s_sel_o),
        .s_adr_o    (s_adr_o),
        .s_dat_o    (s_dat_o),
        .s_ack_i    (s_ack_i),
        .s_dat_i    (s_dat_i),
        .fault_adr_o(fault_adr_o),
        .fault_cnt_o(fault_cnt_o),
        .err_irq_o  (err_irq_o),
        .irq_clr_i  (irq_clr_i)
    );

    initial wb_clk_i = 1'b0;
    always #5 wb_clk_i = ~wb_clk_i;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // One master access. slv<0: unmapped; lat<0: slave never acks; lat = valid cycles before ack.
    // stray: another slave acking while the target is still waiting. clr_cyc: cycle to pulse irq_clr_i.
    task automatic access(input logic [31:0] adr, input logic we, input int slv, input int lat,
                          input logic [31:0] rdat, input int stray, input int clr_cyc,
                          output int n_ack, output int n_valid, output logic [3:0] first_valid);
        int   vcnt;
        int   n;
        bit   done;
        logic idle_bad;
        vcnt = 0; n = 0; done = 0; idle_bad = 1'b0; first_valid = '0;
        wbs_adr_i = adr;
        wbs_we_i  = we;
        wbs_dat_i = ~adr;
        wbs_sel_i = 4'hF;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        irq_clr_i = (clr_cyc == 1);
        if (slv >= 0) s_dat_i[slv*32 +: 32] = rdat;
        exp_q.push_back((slv < 0 || lat < 0) ? ERR_DATA : rdat);
        while (!done && n < 300) begin
            @(negedge wb_clk_i);
            n++;
            if (s_valid_o != '0) begin
                if (vcnt == 0) begin
                    first_valid = s_valid_o;
                    check("bcast_adr", s_adr_o, adr);
                    check("bcast_we", 32'(s_we_o), 32'(we));
                end
                vcnt++;
            end
            if (wbs_ack_o) begin
                if (exp_q.size() == 0) check("unexpected_ack", 32'd1, 32'd0);
                else check("ack_data", wbs_dat_o, exp_q.pop_front());
                done = 1;
            end else if (wbs_dat_o != '0) begin
                idle_bad = 1'b1;
            end
            @(posedge wb_clk_i);
            #1;
            irq_clr_i = (n + 1 == clr_cyc);
            s_ack_i   = '0;
            if (!done && slv >= 0 && lat >= 0 && vcnt >= lat) s_ack_i[slv] = 1'b1;
            else if (!done && stray >= 0 && vcnt > 0) s_ack_i[stray] = 1'b1;
        end
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        irq_clr_i = 1'b0;
        s_ack_i   = '0;
        if (!done) begin
            check("ack_seen", 32'd0, 32'd1);
            exp_q.delete();
        end
        check("dat_zero_idle", 32'(idle_bad), 32'd0);
        n_ack   = n;
        n_valid = vcnt;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         na;
        int         nv;
        logic [3:0] fv;

        wb_rst_i  = 1'b1;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        wbs_we_i  = 1'b0;
        wbs_sel_i = '0;
        wbs_adr_i = '0;
        wbs_dat_i = '0;
        s_ack_i   = '0;
        s_dat_i   = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
        irq_clr_i = 1'b0;
        repeat (2) @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check("rst_ack", 32'(wbs_ack_o), 32'd0);
        check("rst_dat", wbs_dat_o, 32'd0);
        check("rst_valid", 32'(s_valid_o), 32'd0);
        check("rst_fadr", fault_adr_o, 32'd0);
        check("rst_fcnt", 32'(fault_cnt_o), 32'd0);
        check("rst_irq", 32'(err_irq_o), 32'd0);
        @(posedge wb_clk_i);
        #1;

        // Read of slave 1, acked two cycles after its valid.
        access(32'h3000_0104, 1'b0, 1, 2, 32'h1234_5678, -1, 0, na, nv, fv);
        check("t1_valid", 32'(fv), 32'h2);
        check("t1_latency", na, 4);
        check("t1_irq", 32'(err_irq_o), 32'd0);

        // Unmapped write.
        access(32'h3000_0F00, 1'b1, -1, 0, 32'h0, -1, 0, na, nv, fv);
        check("t2_latency", na, 2);
        check("t2_valid_cycles", nv, 0);
        check("t2_fadr", fault_adr_o, 32'h3000_0F00);
        check("t2_fcnt", 32'(fault_cnt_o), 32'd1);
        check("t2_irq", 32'(err_irq_o), 32'd1);

        // Slave 3 never acks: timeout.
        access(32'h3800_0000, 1'b0, 3, -1, 32'h0, -1, 0, na, nv, fv);
        check("t3_valid", 32'(fv), 32'h8);
        check("t3_valid_cycles", nv, TIMEOUT);
        check("t3_latency", na, TIMEOUT + 2);
        check("t3_fadr", fault_adr_o, 32'h3800_0000);
        check("t3_fcnt", 32'(fault_cnt_o), 32'd2);

        // Slave 2 acks while slave 0 is selected; only slave 0's ack completes.
        access(32'h3000_0004, 1'b0, 0, 3, 32'hCAFE_0000, 2, 0, na, nv, fv);
        check("t4_valid", 32'(fv), 32'h1);
        check("t4_latency", na, 5);

        // Clear coincident with fault entry, then clear during the ERR cycle.
        access(32'h3000_0F04, 1'b0, -1, 0, 32'h0, -1, 1, na, nv, fv);
        check("t4_clr_entry_irq", 32'(err_irq_o), 32'd0);
        check("t4_clr_entry_fcnt", 32'(fault_cnt_o), 32'd0);
        check("t4_clr_entry_fadr", fault_adr_o, 32'h3000_0F04);
        access(32'h3000_0F08, 1'b0, -1, 0, 32'h0, -1, 2, na, nv, fv);
        check("t4_clr_err_irq", 32'(err_irq_o), 32'd0);
        check("t4_clr_err_fcnt", 32'(fault_cnt_o), 32'd0);

        // Master abort in WAIT.
        wbs_adr_i = 32'h3000_0104;
        wbs_we_i  = 1'b0;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        repeat (3) @(negedge wb_clk_i);
        check("t5_valid_wait", 32'(s_valid_o), 32'h2);
        @(posedge wb_clk_i);
        #1 wbs_cyc_i = 1'b0;
        @(negedge wb_clk_i);
        check("t5_abort_ack", 32'(wbs_ack_o), 32'd0);
        check("t5_abort_valid", 32'(s_valid_o), 32'd0);
        wbs_stb_i = 1'b0;
        repeat (2) @(negedge wb_clk_i);
        check("t5_abort_nofault", 32'(fault_cnt_o), 32'd0);

        // Reset mid-WAIT, then a late slave ack.
        @(posedge wb_clk_i);
        #1;
        wbs_adr_i = 32'h3000_0100;
        wbs_cyc_i = 1'b1;
        wbs_stb_i = 1'b1;
        repeat (2) @(negedge wb_clk_i);
        @(posedge wb_clk_i);
        #1 wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        wb_rst_i  = 1'b0;
        wbs_cyc_i = 1'b0;
        wbs_stb_i = 1'b0;
        s_ack_i[1] = 1'b1;
        s_dat_i[32 +: 32] = 32'h5555_AAAA;
        @(negedge wb_clk_i);
        check("t5_rst_ack", 32'(wbs_ack_o), 32'd0);
        check("t5_rst_dat", wbs_dat_o, 32'd0);
        check("t5_rst_valid", 32'(s_valid_o), 32'd0);
        check("t5_rst_fadr", fault_adr_o, 32'd0);
        check("t5_rst_fcnt", 32'(fault_cnt_o), 32'd0);
        check("t5_rst_irq", 32'(err_irq_o), 32'd0);
        @(posedge wb_clk_i);
        #1 s_ack_i = '0;

        // Fault counter saturation.
        for (int i = 0; i < 256; i++) begin
            access(32'h3000_0F00 | 32'(i), 1'b0, -1, 0, 32'h0, -1, 0, na, nv, fv);
        end
        check("t6_fcnt_256", 32'(fault_cnt_o), 32'hFF);
        access(32'h3000_0FFC, 1'b1, -1, 0, 32'h0, -1, 0, na, nv, fv);
        check("t6_fcnt_sat", 32'(fault_cnt_o), 32'hFF);
        check("t6_fadr", fault_adr_o, 32'h3000_0FFC);
        check("t6_irq", 32'(err_irq_o), 32'd1);

        // Back-to-back reads of slaves 0, 3, 0.
        access(32'h3000_0010, 1'b0, 0, 1, 32'h0000_1111, -1, 0, na, nv, fv);
        check("t6_b2b0_valid", 32'(fv), 32'h1);
        access(32'h3800_1234, 1'b0, 3, 2, 32'h3333_3333, -1, 0, na, nv, fv);
        check("t6_b2b1_valid", 32'(fv), 32'h8);
        access(32'h3000_0020, 1'b0, 0, 1, 32'h0000_2222, -1, 0, na, nv, fv);
        check("t6_b2b2_valid", 32'(fv), 32'h1);
        check("t6_b2b2_latency", na, 3);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
